// File: rtl/vcfg_if.sv
// Request/response bus between the scalar core and the vector configuration unit.
// Both channels use the same handshake: the source raises valid together with its
// payload and holds both stable until the cycle where valid & ready are both high;
// that cycle is the transfer. ready may be raised or dropped independently of valid.
interface vcfg_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_insn;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rd;
    logic            resp_illegal;

    // Scalar core side.
    modport master (
        output req_valid, req_insn, req_rs1, req_rs2, resp_ready,
        input  req_ready, resp_valid, resp_rd, resp_illegal
    );

    // Configuration unit side.
    modport slave (
        input  req_valid, req_insn, req_rs1, req_rs2, resp_ready,
        output req_ready, resp_valid, resp_rd, resp_illegal
    );
endinterface

// File: rtl/vcfg_unit.sv
// Executes vsetvli / vsetivli / vsetvl: decodes the configuration instruction,
// validates the requested vtype (including the vlut/vreuse fields), computes VLMAX
// and the new vl, owns the architectural vl/vtype and returns rd to the core.
// vtype layout: [2:0] vlmul, [5:3] vsew, [6] vta, [7] vma, [10:8] vlut,
//               [11] vreuse, [12] vill.
module vcfg_unit #(
    parameter int XLEN = 64,
    parameter int VLEN = 1024,
    parameter int ELEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            backend_idle_i,
    vcfg_if.slave           bus,
    output logic [XLEN-1:0] vl_o,
    output logic [12:0]     vtype_o,
    output logic [1:0]      dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [6:0]      OPCODE_VEC = 7'b1010111;
    localparam logic [2:0]      OPCFG      = 3'b111;
    localparam logic [2:0]      LMUL_RSVD  = 3'b100;
    localparam logic [2:0]      VLUT_MAX   = 3'd5;   // CB256
    localparam logic [12:0]     VTYPE_VILL = 13'h1000;
    localparam logic [10:0]     ELEN_W     = 11'(ELEN);
    localparam logic [XLEN-1:0] VLEN_X     = XLEN'(VLEN);

    state_e          state;
    logic [31:0]     insn_q;
    logic [XLEN-1:0] rs1_q, rs2_q;
    logic [11:0]     cand_q;
    logic            vill_q, illegal_q, keep_q;
    logic [XLEN-1:0] vlmax_q, avl_q;
    logic            resp_valid_q, resp_illegal_q;
    logic [XLEN-1:0] resp_rd_q;
    logic [XLEN-1:0] vl_q;
    logic [12:0]     vtype_q;

    // Decode fields of the latched instruction.
    logic       is_cfg, is_vli, is_ivli, is_vl, legal;
    logic [4:0] rd_f, rs1_f;
    assign is_cfg  = (insn_q[6:0] == OPCODE_VEC) && (insn_q[14:12] == OPCFG);
    assign is_vli  = ~insn_q[31];
    assign is_ivli = (insn_q[31:30] == 2'b11);
    assign is_vl   = (insn_q[31:25] == 7'b1000000);
    assign legal   = is_cfg && (is_vli || is_ivli || is_vl);
    assign rd_f    = insn_q[11:7];
    assign rs1_f   = insn_q[19:15];

    logic [11:0]     cand;
    logic            high_bits;
    logic [2:0]      vlmul, vsew, vlut, frac_shift;
    logic [10:0]     sew_bits, elen_frac;
    logic            vill;
    logic [XLEN-1:0] vlmax_base, vlmax, avl;

    // Assemble the requested vtype from the immediate or rs2, depending on the form.
    always_comb begin
        cand      = '0;
        high_bits = 1'b0;
        if (is_ivli) begin
            cand[7:0]  = insn_q[27:20];
            cand[10:8] = {1'b0, insn_q[29:28]};
        end else if (is_vl) begin
            cand      = rs2_q[11:0];
            high_bits = |rs2_q[XLEN-1:12];
        end else begin
            cand[10:0] = insn_q[30:20];
        end
    end

    assign vlmul      = cand[2:0];
    assign vsew       = cand[5:3];
    assign vlut       = cand[10:8];
    assign frac_shift = 3'(3'd0 - vlmul);          // mf2->1, mf4->2, mf8->3
    assign sew_bits   = 11'd8 << vsew;
    assign elen_frac  = ELEN_W >> frac_shift;
    assign vill       = high_bits
                      || (vlmul == LMUL_RSVD)
                      || (sew_bits > ELEN_W)
                      || (vlmul[2] && (vlmul != LMUL_RSVD) && (sew_bits > elen_frac))
                      || (vlut > VLUT_MAX);
    assign vlmax_base = VLEN_X >> (4'(vsew) + 4'd3);

    // VLMAX scales by LMUL; forced to zero for an illegal vtype.
    always_comb begin
        vlmax = vlmul[2] ? (vlmax_base >> frac_shift) : (vlmax_base << vlmul[1:0]);
        if (vill) vlmax = '0;
    end

    // AVL source: uimm5, rs1, or all-ones when rs1=x0 asks for VLMAX.
    always_comb begin
        if (is_ivli)           avl = XLEN'(insn_q[19:15]);
        else if (rs1_f != '0)  avl = rs1_q;
        else                   avl = '1;
    end

    // New vl once the backend is drained.
    logic [XLEN-1:0] new_vl;
    always_comb begin
        new_vl = (avl_q < vlmax_q) ? avl_q : vlmax_q;
        if (vill_q)      new_vl = '0;
        else if (keep_q) new_vl = vl_q;
    end

    // Control FSM plus architectural vl/vtype and the registered response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            insn_q         <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            cand_q         <= '0;
            vill_q         <= 1'b0;
            illegal_q      <= 1'b0;
            keep_q         <= 1'b0;
            vlmax_q        <= '0;
            avl_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_illegal_q <= 1'b0;
            resp_rd_q      <= '0;
            vl_q           <= '0;
            vtype_q        <= VTYPE_VILL;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        insn_q <= bus.req_insn;
                        rs1_q  <= bus.req_rs1;
                        rs2_q  <= bus.req_rs2;
                        state  <= DECODE;
                    end
                end
                DECODE: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        cand_q    <= cand;
                        vill_q    <= vill;
                        illegal_q <= ~legal;
                        keep_q    <= ~is_ivli && (rs1_f == '0) && (rd_f == '0);
                        vlmax_q   <= vlmax;
                        avl_q     <= avl;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else if (illegal_q) begin
                        resp_rd_q      <= '0;
                        resp_illegal_q <= 1'b1;
                        resp_valid_q   <= 1'b1;
                        state          <= RESP;
                    end else if (backend_idle_i || keep_q) begin
                        vl_q           <= new_vl;
                        vtype_q        <= vill_q ? VTYPE_VILL : {1'b0, cand_q};
                        resp_rd_q      <= new_vl;
                        resp_illegal_q <= 1'b0;
                        resp_valid_q   <= 1'b1;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = (state == IDLE) && !rst_i;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rd      = resp_rd_q;
    assign bus.resp_illegal = resp_illegal_q;
    assign vl_o             = vl_q;
    assign vtype_o          = vtype_q;
    assign dbg_state_o      = state;
endmodule

// File: tb/tb_vcfg_unit.sv
// Directed bench for vcfg_unit: reset checks, a table of single-instruction vectors
// with hand-computed results, and hand sequences for drain stall, flush, response
// backpressure and the drain-skipping forms.
module tb_vcfg_unit;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            idle = 1'b1;
    logic [XLEN-1:0] vl;
    logic [12:0]     vtype;
    logic [1:0]      dbg_state;

    int checks = 0;
    int errors = 0;

    vcfg_if #(.XLEN(XLEN)) bus ();

    vcfg_unit #(.XLEN(XLEN), .VLEN(1024), .ELEN(64)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .backend_idle_i (idle),
        .bus            (bus),
        .vl_o           (vl),
        .vtype_o        (vtype),
        .dbg_state_o    (dbg_state)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     insn;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] exp_rd;
        logic            exp_illegal;
        logic [XLEN-1:0] exp_vl;
        logic [12:0]     exp_vtype;
    } vec_t;

    vec_t vecs[$];

    // Instruction encoders.
    function automatic logic [31:0] enc_vli(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [10:0] zimm);
        return {1'b0, zimm, rs1, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] enc_ivli(input logic [4:0] rd, input logic [4:0] uimm,
                                             input logic [9:0] zimm);
        return {2'b11, zimm, uimm, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] enc_vl(input logic [4:0] rd, input logic [4:0] rs1);
        return {7'b1000000, 5'd6, rs1, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic vec_t mk(input logic [31:0] insn, input logic [XLEN-1:0] rs1,
                                input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] rd,
                                input logic ill, input logic [XLEN-1:0] v,
                                input logic [12:0] vt);
        vec_t r;
        r.insn = insn; r.rs1 = rs1; r.rs2 = rs2; r.exp_rd = rd;
        r.exp_illegal = ill; r.exp_vl = v; r.exp_vtype = vt;
        return r;
    endfunction

    // Scoreboard compare.
    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: present a request and hold it until accepted.
    task automatic send(input logic [31:0] insn, input logic [XLEN-1:0] rs1,
                        input logic [XLEN-1:0] rs2);
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_insn  = insn;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got ready=0 expected ready=1");
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Wait (bounded) for resp_valid; returns with the response visible at a negedge.
    task automatic wait_resp(input string name, output logic ok);
        int n = 0;
        while (!bus.resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = bus.resp_valid;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_resp_timeout got valid=0 expected valid=1", name);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic ok;
        string nm;
        nm = $sformatf("v%0d", idx);
        send(v.insn, v.rs1, v.rs2);
        wait_resp(nm, ok);
        if (ok) begin
            chk({nm, "_rd"}, bus.resp_rd, v.exp_rd);
            chk({nm, "_illegal"}, XLEN'(bus.resp_illegal), XLEN'(v.exp_illegal));
            chk({nm, "_vl"}, vl, v.exp_vl);
            chk({nm, "_vtype"}, XLEN'(vtype), XLEN'(v.exp_vtype));
        end
        @(negedge clk);
    endtask

    initial begin
        logic ok;
        bus.req_valid  = 1'b0;
        bus.req_insn   = '0;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.resp_ready = 1'b1;

        // Vector table: vlmul/vsew/vta/vma/vlut fields, VLEN=1024, ELEN=64.
        vecs.push_back(mk(enc_vli(5'd1, 5'd5, 11'h010), 64'd100, 64'd0, 64'd32, 1'b0, 64'd32, 13'h010));
        vecs.push_back(mk(enc_vli(5'd1, 5'd5, 11'h303), 64'd100, 64'd0, 64'd100, 1'b0, 64'd100, 13'h303));
        vecs.push_back(mk(enc_ivli(5'd2, 5'd7, 10'h00F), 64'd0, 64'd0, 64'd7, 1'b0, 64'd7, 13'h00F));
        vecs.push_back(mk(enc_ivli(5'd2, 5'd7, 10'h01D), 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 13'h1000));
        vecs.push_back(mk(enc_vl(5'd1, 5'd5), 64'd100, 64'h004, 64'd0, 1'b0, 64'd0, 13'h1000));
        vecs.push_back(mk(enc_vl(5'd1, 5'd5), 64'd100, 64'hA10, 64'd32, 1'b0, 64'd32, 13'hA10));
        vecs.push_back(mk(enc_vl(5'd1, 5'd5), 64'd100, 64'h100_0000_0010, 64'd0, 1'b0, 64'd0, 13'h1000));
        vecs.push_back(mk(enc_vl(5'd1, 5'd5), 64'd100, 64'h610, 64'd0, 1'b0, 64'd0, 13'h1000));
        vecs.push_back(mk(enc_vli(5'd1, 5'd5, 11'h510), 64'd100, 64'd0, 64'd32, 1'b0, 64'd32, 13'h510));
        vecs.push_back(mk(enc_vli(5'd0, 5'd0, 11'h011), 64'd0, 64'd0, 64'd32, 1'b0, 64'd32, 13'h011));
        vecs.push_back(mk(enc_vli(5'd3, 5'd0, 11'h011), 64'd0, 64'd0, 64'd64, 1'b0, 64'd64, 13'h011));
        vecs.push_back(mk(32'h0000_0057 | 32'h0000_0080, 64'd0, 64'd0, 64'd0, 1'b1, 64'd64, 13'h011));
        vecs.push_back(mk(enc_vli(5'd1, 5'd5, 11'h0DA), 64'd50, 64'd0, 64'd50, 1'b0, 64'd50, 13'h0DA));
        vecs.push_back(mk(enc_vli(5'd1, 5'd5, 11'h000), 64'h1_0000_0005, 64'd0, 64'd128, 1'b0, 64'd128, 13'h000));
        vecs.push_back(mk(enc_vli(5'd1, 5'd5, 11'h020), 64'd100, 64'd0, 64'd0, 1'b0, 64'd0, 13'h1000));
        vecs.push_back(mk(enc_vli(5'd1, 5'd5, 11'h005), 64'd100, 64'd0, 64'd16, 1'b0, 64'd16, 13'h005));
        vecs.push_back(mk(enc_ivli(5'd2, 5'd31, 10'h000), 64'd0, 64'd0, 64'd31, 1'b0, 64'd31, 13'h000));

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready", XLEN'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", XLEN'(bus.resp_valid), 64'd0);
        chk("rst_resp_rd", bus.resp_rd, 64'd0);
        chk("rst_resp_illegal", XLEN'(bus.resp_illegal), 64'd0);
        chk("rst_vl", vl, 64'd0);
        chk("rst_vtype", XLEN'(vtype), 64'h1000);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", XLEN'(bus.req_ready), 64'd1);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Drain stall: no commit and no response while the backend is busy.
        idle = 1'b0;
        send(enc_vli(5'd1, 5'd5, 11'h000), 64'd10, 64'd0);
        repeat (10) @(negedge clk);
        chk("stall_resp_valid", XLEN'(bus.resp_valid), 64'd0);
        chk("stall_vl", vl, 64'd31);
        chk("stall_state", XLEN'(dbg_state), 64'd2);
        idle = 1'b1;
        wait_resp("stall", ok);
        if (ok) begin
            chk("stall_rd", bus.resp_rd, 64'd10);
            chk("stall_vl_after", vl, 64'd10);
        end
        @(negedge clk);

        // Flush while waiting in DRAIN.
        idle = 1'b0;
        send(enc_vli(5'd1, 5'd5, 11'h008), 64'd200, 64'd0);
        @(negedge clk);
        chk("flush_drain_state", XLEN'(dbg_state), 64'd2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_drain_idle", XLEN'(dbg_state), 64'd0);
        chk("flush_drain_ready", XLEN'(bus.req_ready), 64'd1);
        chk("flush_drain_vl", vl, 64'd10);
        chk("flush_drain_vtype", XLEN'(vtype), 64'h000);
        chk("flush_drain_valid", XLEN'(bus.resp_valid), 64'd0);

        // Flush while in DECODE.
        send(enc_vli(5'd1, 5'd5, 11'h008), 64'd200, 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_dec_idle", XLEN'(dbg_state), 64'd0);
        chk("flush_dec_vl", vl, 64'd10);
        idle = 1'b1;

        // Response backpressure; a flush during RESP is ignored.
        bus.resp_ready = 1'b0;
        send(enc_vli(5'd1, 5'd5, 11'h008), 64'd200, 64'd0);
        wait_resp("bp", ok);
        for (int k = 0; k < 5; k++) begin
            flush = (k == 2);
            @(negedge clk);
            chk($sformatf("bp_valid_%0d", k), XLEN'(bus.resp_valid), 64'd1);
            chk($sformatf("bp_rd_%0d", k), bus.resp_rd, 64'd64);
        end
        flush = 1'b0;
        chk("bp_vtype", XLEN'(vtype), 64'h008);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", XLEN'(bus.resp_valid), 64'd0);

        // Keep-vl and illegal forms complete without waiting for the backend.
        idle = 1'b0;
        send(enc_vli(5'd0, 5'd0, 11'h000), 64'd0, 64'd0);
        wait_resp("keep", ok);
        if (ok) begin
            chk("keep_rd", bus.resp_rd, 64'd64);
            chk("keep_vl", vl, 64'd64);
            chk("keep_vtype", XLEN'(vtype), 64'h000);
        end
        @(negedge clk);
        send(32'h0000_0033, 64'd5, 64'd0);
        wait_resp("ill", ok);
        if (ok) begin
            chk("ill_flag", XLEN'(bus.resp_illegal), 64'd1);
            chk("ill_rd", bus.resp_rd, 64'd0);
            chk("ill_vl", vl, 64'd64);
        end
        @(negedge clk);
        idle = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
